// File: rtl/cnn_layer_accel_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_pkg
// Shared definitions for the cnn_layer_accel stream loader:
//   - loader FSM state encoding
//   - sequence word field layout: [12] RM, [11] RST, [10] P, [9:0] SEQ
//   - column-0 SEQ seed values and the words-per-column count
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_layer_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_SEQ,
    ST_GAP,
    ST_PIX,
    ST_DONE
  } loader_state_e;

  localparam int SEQ_RM_BIT    = 12;
  localparam int SEQ_RST_BIT   = 11;
  localparam int SEQ_P_BIT     = 10;
  localparam int SEQ_FIELD_MSB = 9;
  localparam int SEQ_FIELD_LSB = 0;
  localparam int SEQ_FIELD_W   = SEQ_FIELD_MSB - SEQ_FIELD_LSB + 1;

  localparam int WORDS_PER_COL = 5;

  // SEQ values used by output column 0; later columns derive from these.
  function automatic logic [SEQ_FIELD_W-1:0] init_seq(input logic [2:0] word);
    logic [SEQ_FIELD_W-1:0] val;
    case (word)
      3'd0:    val = 10'd0;
      3'd1:    val = 10'd2;
      3'd2:    val = 10'd512;
      3'd3:    val = 10'd513;
      3'd4:    val = 10'd514;
      default: val = 10'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_seq_word_gen.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_seq_word_gen
// Produces the sequence word for output column c, word w combinationally and
// remembers the SEQ field of each word of the previous column, since every
// column after the first is derived from the one before it.
// Ports:
//   clk_500MHz   in   clock
//   rst_n        in   async active-low reset
//   col_idx      in   current output column c
//   word_idx     in   current word w within the column (0..4)
//   advance      in   current word was accepted; record its SEQ for column c+1
//   seq_word     out  {RM, RST, P, SEQ}
// -----------------------------------------------------------------------------
module cnn_layer_accel_seq_word_gen
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_CNT_W          = 11
) (
  input  logic                        clk_500MHz,
  input  logic                        rst_n,
  input  logic [C_CNT_W-1:0]          col_idx,
  input  logic [2:0]                  word_idx,
  input  logic                        advance,
  output logic [C_SEQ_DATA_WIDTH-1:0] seq_word
);

  logic [WORDS_PER_COL-1:0][SEQ_FIELD_W-1:0] prev_seq;
  logic [SEQ_FIELD_W-1:0]                    next_seq;

  // One register per word slot; only the slot being emitted is overwritten,
  // so slots not yet reached still hold the previous column's value.
  generate
    for (genvar gi = 0; gi < WORDS_PER_COL; gi++) begin : g_prev
      logic [SEQ_FIELD_W-1:0] seq_q, seq_d;

      always_comb begin
        seq_d = seq_q;
        if (advance && (word_idx == 3'(gi)))
          seq_d = next_seq;
      end

      always_ff @(posedge clk_500MHz or negedge rst_n) begin
        if (!rst_n) seq_q <= '0;
        else        seq_q <= seq_d;
      end

      assign prev_seq[gi] = seq_q;
    end
  endgenerate

  always_comb begin
    next_seq = '0;
    if (col_idx == '0) begin
      next_seq = init_seq(word_idx);
    end else begin
      case (word_idx)
        3'd0:    next_seq = prev_seq[0] + 10'd1;
        // w1 advances by 2 only on even columns, i.e. every other column
        3'd1:    next_seq = col_idx[0] ? prev_seq[1] : prev_seq[1] + 10'd2;
        3'd2:    next_seq = prev_seq[2] + 10'd1;
        3'd3:    next_seq = prev_seq[3] + 10'd1;
        3'd4:    next_seq = prev_seq[4] + 10'd1;
        default: next_seq = '0;
      endcase
    end
  end

  always_comb begin
    seq_word = '0;
    seq_word[SEQ_FIELD_MSB:SEQ_FIELD_LSB] = next_seq;
    seq_word[SEQ_RST_BIT] = (word_idx == 3'd0);
    seq_word[SEQ_RM_BIT]  = (word_idx == 3'd4);
    if (word_idx == 3'd0)      seq_word[SEQ_P_BIT] = ~col_idx[0];
    else if (word_idx == 3'd1) seq_word[SEQ_P_BIT] = col_idx[0];
  end

endmodule

// File: rtl/cnn_layer_accel_stream_loader.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_stream_loader
// Feeder for cnn_layer_accel_octo. On start: pulses new_map, emits the
// 5*(cols-K+1) sequence words, idles one cycle, then forwards rows*cols
// pixels from the upstream valid/ready source through a one-entry register.
// Optional macro: STREAM_LOADER_CFG_CHECK_EN rejects illegal geometry at start
// and flags it on cfg_err; without it cfg_err is tied low.
// Ports:
//   clk_500MHz, rst_n          clock, async active-low reset
//   start, abort               run request (IDLE only) / return to IDLE
//   num_input_rows_cfg/cols    map geometry (actual counts)
//   kernel_size_cfg            kernel edge K
//   pix_in/_valid/_rdy         upstream row-major pixel stream
//   new_map                    one-cycle pulse at run start
//   datain/_valid              downstream bus (seq words zero-extended)
//   seq_datain_tag/_rdy        sequence beat tag and its ready
//   pixel_datain_tag/_rdy      pixel beat tag and its ready
//   busy, done, cfg_err        status
// -----------------------------------------------------------------------------
module cnn_layer_accel_stream_loader
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_MAX_DIM        = 1024
) (
  input  logic                             clk_500MHz,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [$clog2(C_MAX_DIM):0]       num_input_rows_cfg,
  input  logic [$clog2(C_MAX_DIM):0]       num_input_cols_cfg,
  input  logic [3:0]                       kernel_size_cfg,
  input  logic [C_PIXEL_WIDTH-1:0]         pix_in,
  input  logic                             pix_in_valid,
  output logic                             pix_in_rdy,
  output logic                             new_map,
  output logic [C_PIXEL_WIDTH-1:0]         datain,
  output logic                             datain_valid,
  output logic                             seq_datain_tag,
  input  logic                             seq_datain_rdy,
  output logic                             pixel_datain_tag,
  input  logic                             pixel_datain_rdy,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int CW = $clog2(C_MAX_DIM) + 1;
  localparam int PW = 2 * CW;

  loader_state_e                state_q, state_d;
  logic [CW-1:0]                n_oc_q, n_oc_d;
  logic [CW-1:0]                col_q, col_d;
  logic [2:0]                   word_q, word_d;
  logic [PW-1:0]                rem_q, rem_d;
  logic [C_PIXEL_WIDTH-1:0]     pix_data_q, pix_data_d;
  logic                         pix_valid_q, pix_valid_d;
  logic [C_SEQ_DATA_WIDTH-1:0]  seq_word;
  logic                         seq_fire, pix_out_fire, pix_load, launch;

`ifdef STREAM_LOADER_CFG_CHECK_EN
  logic cfg_err_q, cfg_err_d, cfg_bad;

  always_comb begin
    cfg_bad = (num_input_rows_cfg == '0) || (num_input_cols_cfg == '0) ||
              (kernel_size_cfg == '0) ||
              (CW'(kernel_size_cfg) > num_input_rows_cfg) ||
              (CW'(kernel_size_cfg) > num_input_cols_cfg) ||
              (num_input_rows_cfg > CW'(C_MAX_DIM)) ||
              (num_input_cols_cfg > CW'(C_MAX_DIM));
  end
`endif

  cnn_layer_accel_seq_word_gen #(
    .C_SEQ_DATA_WIDTH (C_SEQ_DATA_WIDTH),
    .C_CNT_W          (CW)
  ) u_seq_word_gen (
    .clk_500MHz (clk_500MHz),
    .rst_n      (rst_n),
    .col_idx    (col_q),
    .word_idx   (word_q),
    .advance    (seq_fire),
    .seq_word   (seq_word)
  );

  always_comb begin
    state_d     = state_q;
    n_oc_d      = n_oc_q;
    col_d       = col_q;
    word_d      = word_q;
    rem_d       = rem_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    launch      = 1'b0;
`ifdef STREAM_LOADER_CFG_CHECK_EN
    cfg_err_d   = cfg_err_q;
`endif

    seq_fire     = (state_q == ST_SEQ) && seq_datain_rdy;
    pix_out_fire = (state_q == ST_PIX) && pix_valid_q && pixel_datain_rdy;
    // Accept upstream only when the output register is empty or draining now.
    pix_in_rdy   = (state_q == ST_PIX) && (rem_q != '0) &&
                   (!pix_valid_q || pixel_datain_rdy);
    pix_load     = pix_in_rdy && pix_in_valid;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef STREAM_LOADER_CFG_CHECK_EN
          cfg_err_d = cfg_bad;
          launch    = !cfg_bad;
`else
          launch    = 1'b1;
`endif
        end
        if (launch) begin
          state_d = ST_MAP;
          n_oc_d  = num_input_cols_cfg - CW'(kernel_size_cfg) + CW'(1);
          rem_d   = PW'(num_input_rows_cfg) * PW'(num_input_cols_cfg);
          col_d   = '0;
          word_d  = '0;
        end
      end
      ST_MAP: state_d = ST_SEQ;
      ST_SEQ: begin
        if (seq_fire) begin
          if (word_q == 3'(WORDS_PER_COL - 1)) begin
            word_d = '0;
            col_d  = col_q + CW'(1);
            if (col_q == n_oc_q - CW'(1))
              state_d = ST_GAP;
          end else begin
            word_d = word_q + 3'd1;
          end
        end
      end
      ST_GAP: state_d = ST_PIX;
      ST_PIX: begin
        if (pix_load) begin
          pix_data_d  = pix_in;
          pix_valid_d = 1'b1;
          rem_d       = rem_q - PW'(1);
        end else if (pix_out_fire) begin
          pix_valid_d = 1'b0;
          // Nothing left upstream and the register just drained: run over.
          if (rem_q == '0)
            state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_500MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_oc_q      <= '0;
      col_q       <= '0;
      word_q      <= '0;
      rem_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
`ifdef STREAM_LOADER_CFG_CHECK_EN
      cfg_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_oc_q      <= n_oc_d;
      col_q       <= col_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
`ifdef STREAM_LOADER_CFG_CHECK_EN
      cfg_err_q   <= cfg_err_d;
`endif
    end
  end

  always_comb begin
    datain = '0;
    if (state_q == ST_SEQ)
      datain = C_PIXEL_WIDTH'(seq_word);
    else if ((state_q == ST_PIX) && pix_valid_q)
      datain = pix_data_q;
  end

  assign new_map          = (state_q == ST_MAP);
  assign seq_datain_tag   = (state_q == ST_SEQ);
  assign pixel_datain_tag = (state_q == ST_PIX) && pix_valid_q;
  assign datain_valid     = seq_datain_tag || pixel_datain_tag;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
`ifdef STREAM_LOADER_CFG_CHECK_EN
  assign cfg_err          = cfg_err_q;
`else
  assign cfg_err          = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_stream_loader.sv
module tb_cnn_layer_accel_stream_loader;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] rows_cfg = '0;
  logic [CW-1:0] cols_cfg = '0;
  logic [3:0]    k_cfg = '0;
  logic [15:0]   pix_in = '0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_rdy;
  logic          new_map;
  logic [15:0]   datain;
  logic          datain_valid;
  logic          seq_tag, pix_tag;
  logic          seq_rdy = 1'b1;
  logic          pix_rdy = 1'b1;
  logic          busy, done, cfg_err;
  logic [23:0]   outs_vec;

  cnn_layer_accel_stream_loader dut (
    .clk_500MHz         (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .num_input_rows_cfg (rows_cfg),
    .num_input_cols_cfg (cols_cfg),
    .kernel_size_cfg    (k_cfg),
    .pix_in             (pix_in),
    .pix_in_valid       (pix_in_valid),
    .pix_in_rdy         (pix_in_rdy),
    .new_map            (new_map),
    .datain             (datain),
    .datain_valid       (datain_valid),
    .seq_datain_tag     (seq_tag),
    .seq_datain_rdy     (seq_rdy),
    .pixel_datain_tag   (pix_tag),
    .pixel_datain_rdy   (pix_rdy),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  assign outs_vec = {new_map, datain_valid, seq_tag, pix_tag, busy, done,
                     cfg_err, pix_in_rdy, datain};

  typedef struct {
    bit          is_seq;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] src_q[$];
  logic [15:0] seen_seq[$];
  int          tests = 0;
  int          fails = 0;
  int          src_gen = 0;
  bit          stall_mode = 0;
  bit          pix_fire = 0;
  int          seq_acc_total = 0, pix_acc_total = 0, done_total = 0;
  int          seq_target = -1, pix_target = -1;
  int          seen_base = 0, done_base = 0, pix_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Closed-form sequence word: SEQ of each word is a simple function of c.
  function automatic logic [15:0] model_seq(input int c, input int w);
    int   s;
    logic rm, rst, p;
    rm  = (w == 4);
    rst = (w == 0);
    p   = 1'b0;
    if (w == 0) begin
      s = c;
      p = ((c % 2) == 0);
    end else if (w == 1) begin
      s = 2 + 2 * (c / 2);
      p = ((c % 2) == 1);
    end else begin
      s = 512 + (w - 2) + c;
    end
    s = s % 1024;
    return {3'b000, rm, rst, p, s[9:0]};
  endfunction

  // Upstream pixel source and downstream ready generator.
  int drv_gen = 0;
  int src_idx = 0;
  always @(posedge clk) begin
    #1;
    if (src_gen != drv_gen) begin
      drv_gen      = src_gen;
      src_idx      = 0;
      pix_in_valid = 1'b0;
    end else if (pix_fire) begin
      src_idx++;
    end
    seq_rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    pix_rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pix_fire || !pix_in_valid) begin
      if (src_idx < src_q.size() && (!stall_mode || $urandom_range(0, 1) == 1)) begin
        pix_in_valid = 1'b1;
        pix_in       = src_q[src_idx];
      end else begin
        pix_in_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  bit          hold_pending = 0, gap_due = 0, done_due = 0;
  logic [31:0] hold_val = '0;
  always @(negedge clk) begin
    beat_t e;
    bit    acc;
    if (!rst_n) begin
      pix_fire     = 0;
      hold_pending = 0;
      gap_due      = 0;
      done_due     = 0;
    end else begin
      pix_fire = pix_in_valid && pix_in_rdy;
      if (done || done_due) chk("done_timing", 32'(done), 32'(done_due));
      done_due = 0;
      if (done) done_total++;
      if (gap_due) begin
        chk("gap_idle", 32'({datain_valid, seq_tag, pix_tag}), 32'd0);
        gap_due = 0;
      end
      if (hold_pending)
        chk("stall_hold", 32'({datain_valid, seq_tag, pix_tag, datain}), hold_val);
      acc = datain_valid && ((seq_tag && seq_rdy) || (pix_tag && pix_rdy));
      if (acc) begin
        hold_pending = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got datain 0x%0h, expected no beat", datain);
        end else begin
          e = exp_q.pop_front();
          chk(e.is_seq ? "seq_word" : "pixel", 32'({seq_tag, pix_tag, datain}),
              32'({e.is_seq, !e.is_seq, e.data}));
        end
        if (seq_tag) begin
          seen_seq.push_back(datain);
          seq_acc_total++;
          if (seq_acc_total == seq_target) gap_due = 1;
        end else begin
          pix_acc_total++;
          if (pix_acc_total == pix_target) done_due = 1;
        end
      end else begin
        hold_pending = datain_valid;
        hold_val     = 32'({datain_valid, seq_tag, pix_tag, datain});
      end
    end
  end

  task automatic launch(input int r, input int c, input int k, input bit stall, input bit mid_start);
    int n_oc;
    logic [15:0] v;
    n_oc      = c - k + 1;
    seen_base = seen_seq.size();
    done_base = done_total;
    pix_base  = pix_acc_total;
    for (int ci = 0; ci < n_oc; ci++)
      for (int w = 0; w < 5; w++)
        exp_q.push_back('{is_seq: 1'b1, data: model_seq(ci, w)});
    seq_target = seq_acc_total + 5 * n_oc;
    src_q.delete();
    for (int i = 0; i < r * c; i++) begin
      v = 16'($urandom);
      src_q.push_back(v);
      exp_q.push_back('{is_seq: 1'b0, data: v});
    end
    pix_target = pix_acc_total + r * c;
    src_gen++;
    stall_mode = stall;
    @(posedge clk); #1;
    start = 1'b1; rows_cfg = CW'(r); cols_cfg = CW'(c); k_cfg = 4'(k);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("new_map_pulse", 32'(new_map), 32'd1);
    chk("busy_in_map", 32'(busy), 32'd1);
    chk("cfg_err_clear_on_start", 32'(cfg_err), 32'd0);
    @(negedge clk);
    chk("first_seq_valid", 32'({datain_valid, seq_tag, new_map}), 32'b110);
    if (mid_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic finish_run();
    for (int cyc = 0; cyc < 20000 && done_total == done_base; cyc++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("done_once", 32'(done_total - done_base), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("cfg_err_low", 32'(cfg_err), 32'd0);
  endtask

  task automatic cleanup();
    exp_q.delete();
    src_q.delete();
    src_gen++;
    seq_target = -1;
    pix_target = -1;
  endtask

  task automatic wait_pixels(input int n);
    for (int cyc = 0; cyc < 5000 && (pix_acc_total - pix_base) < n; cyc++) @(negedge clk);
    chk("reached_pixel_count", 32'((pix_acc_total - pix_base) >= n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] plan [0:9];
    plan = '{16'h0C00, 16'h0002, 16'h0200, 16'h0201, 16'h1202,
             16'h0801, 16'h0402, 16'h0201, 16'h0202, 16'h1203};

    #3;
    chk("reset_outputs", 32'(outs_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10x10, K=3, no stalls: check the documented words directly too
    launch(10, 10, 3, 0, 0);
    finish_run();
    chk("seq_count_10x10", 32'(seen_seq.size() - seen_base), 32'd40);
    for (int i = 0; i < 10; i++) chk("plan_word", 32'(seen_seq[seen_base + i]), 32'(plan[i]));
    chk("plan_word11", 32'(seen_seq[seen_base + 11]), 32'h0004);
    chk("plan_word39", 32'(seen_seq[seen_base + 39]), 32'h1209);

    // Same geometry with random stalls and a start pulse during SEQ
    launch(10, 10, 3, 1, 1);
    finish_run();
    chk("seq_count_stall", 32'(seen_seq.size() - seen_base), 32'd40);

    // Wide map with K=1: w2 SEQ wraps 1023 -> 0
    launch(1, 600, 1, 0, 0);
    finish_run();
    chk("seq_count_600", 32'(seen_seq.size() - seen_base), 32'd3000);
    chk("wrap_1023", 32'(seen_seq[seen_base + 5 * 511 + 2]), 32'h03FF);
    chk("wrap_0", 32'(seen_seq[seen_base + 5 * 512 + 2]), 32'h0000);
    chk("last_word_600", 32'(seen_seq[seen_base + 5 * 599 + 4]), 32'h1059);

`ifdef STREAM_LOADER_CFG_CHECK_EN
    @(posedge clk); #1;
    start = 1'b1; rows_cfg = 11'd10; cols_cfg = 11'd4; k_cfg = 4'd5;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cfg_err_set", 32'({cfg_err, new_map, busy}), 32'b100);
    end
    launch(10, 10, 3, 0, 0);
    finish_run();
`endif

    // Async reset in PIX, then a clean restart from word 0
    launch(10, 10, 3, 0, 0);
    wait_pixels(37);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(outs_vec), 32'd0);
    cleanup();
    @(negedge clk);
    chk("held_in_reset", 32'(outs_vec), 32'd0);
    rst_n = 1'b1;
    launch(10, 10, 3, 1, 0);
    finish_run();
    chk("restart_word0", 32'(seen_seq[seen_base]), 32'h0C00);

    // Abort in PIX
    launch(10, 10, 3, 0, 0);
    wait_pixels(20);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid_low", 32'({datain_valid, pix_tag}), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    cleanup();
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_total - done_base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_stream_loader.md
# cnn_layer_accel_stream_loader

Synthesizable feeder for `cnn_layer_accel_octo`. It replaces bench-side stimulus with hardware: on `start` it pulses `new_map`, generates the per-output-column sequence words from run-time geometry, then forwards the pixel map from an upstream valid/ready source. All traffic leaves on the shared `datain` bus with the seq/pixel tag handshake. It generalises the fixed 10x10, 3x3 sequence pattern to any rows, cols and kernel size up to `C_MAX_DIM`.

## Interface
Parameters:
- `C_PIXEL_WIDTH`, 16, pixel/bus width; must be >= 13.
- `C_SEQ_DATA_WIDTH`, 13, sequence word width: [12] RM, [11] RST, [10] P, [9:0] SEQ.
- `C_MAX_DIM`, 1024, max rows/cols; sets counter widths to clog2(C_MAX_DIM)+1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_500MHz` in 1: sole clock.
- `rst_n` in 1: async active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `abort` in 1: synchronous return to IDLE.
- `num_input_rows_cfg`, `num_input_cols_cfg` in clog2(C_MAX_DIM)+1: rows/cols (actual count, not minus-one).
- `kernel_size_cfg` in 4: kernel edge K.
- `pix_in` in C_PIXEL_WIDTH, `pix_in_valid` in 1, `pix_in_rdy` out 1: upstream pixel stream, row-major.
- `new_map` out 1: one-cycle pulse to accelerator.
- `datain` out C_PIXEL_WIDTH, `datain_valid` out 1: downstream bus; seq words zero-extended.
- `seq_datain_tag` out 1, `seq_datain_rdy` in 1; `pixel_datain_tag` out 1, `pixel_datain_rdy` in 1.
- `busy` out 1, `done` out 1 (one-cycle pulse), `cfg_err` out 1 (sticky until next legal start).

## Operation
- States: IDLE, MAP (new_map pulse), SEQ, GAP, PIX, DONE.
- Transitions:
  - IDLE --start--> MAP, latching cfg.
  - MAP --> SEQ.
  - SEQ --last seq word accepted--> GAP.
  - GAP --> PIX.
  - PIX --last pixel accepted--> DONE.
  - DONE --> IDLE, with `done`=1 in DONE.
- `abort` in any state gives IDLE next cycle; it wins over every other event.
- A beat transfers when `datain_valid` & the tag's matching rdy are both high. Unaccepted `datain` and tags hold stable.
- Sequence: N_OC = cols - K + 1 columns, 5 words each, total 5*N_OC. For column c, word w:
  - c=0: SEQ values 0, 2, 512, 513, 514. Word0 RST=1, P=1.
  - c>=1, w0: SEQ = prev w0 + 1, RST=1, P = ~c[0].
  - c>=1, w1: P = c[0]; SEQ = prev w1 if c odd, prev w1 + 2 if c even.
  - c>=1, w2..w4: SEQ = prev + 1.
  - RM=1 on w4 of every column.
  - SEQ arithmetic is 10-bit modulo 1024 and wraps silently.
- Pixels: rows*cols beats through a one-entry output register.
  - `pix_in_rdy` = PIX & remaining>0 & (!datain_valid | pixel_datain_rdy).
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `start` high at edge T: `new_map`=1 during cycle T+1. First seq word valid with `seq_datain_tag`=1 at T+2.
- Next word follows each acceptance with no bubble.
- GAP is exactly one cycle with both tags and `datain_valid` low.
- Pixel latency is one cycle from `pix_in` acceptance to `datain`. Full throughput holds with no back-pressure.
- `done` is asserted the cycle after the last pixel is accepted. `busy`=1 from MAP through DONE.
- Reset mid-run clears state immediately. Nothing resumes.

## Configuration
- `STREAM_LOADER_CFG_CHECK_EN` defined: `start` with rows=0, cols=0, K=0, K>rows, K>cols, or dims>C_MAX_DIM sets `cfg_err`=1 and stays IDLE, with no `new_map`.
- Without the macro: no check, `cfg_err` is tied 0, and illegal configs are undefined behaviour.

## Structure
- Shared package `cnn_layer_accel_pkg`:
  - state enum;
  - seq word field constants (RM/RST/P bit indices, SEQ field range);
  - initial column-0 SEQ constants {0, 2, 512, 513, 514};
  - words-per-column constant 5.
- One sub-module `cnn_layer_accel_seq_word_gen`: holds the previous-column 5-word register set and produces the next word combinationally from (c, w).

## Test plan
- rows=10, cols=10, K=3, rdy always high -> 40 seq words:
  - words 0..4 = 0x0C00, 0x0002, 0x0200, 0x0201, 0x1202;
  - words 5..9 = 0x0801, 0x0402, 0x0201, 0x0202, 0x1203;
  - word 11 = 0x0004; word 39 = 0x1209;
  - then 100 pixels in order, `done` once.
- Random `seq_datain_rdy`/`pixel_datain_rdy` stalls at 50% -> identical word stream, `datain` stable during every stall, no drops or duplicates.
- cols=600, K=1 -> w2 SEQ wraps 1023 -> 0 without error; total 3000 seq words.
- With `STREAM_LOADER_CFG_CHECK_EN`: K=5, cols=4, `start` -> `cfg_err`=1, no `new_map`, `busy`=0. Then a legal `start` clears `cfg_err`.
- `rst_n` low in PIX after 37 pixels -> all outputs 0 asynchronously. A new `start` restarts from seq word 0.
- `start` pulsed during SEQ -> ignored. `abort` in PIX -> IDLE next cycle, `datain_valid`=0, no `done`.
